// File: rtl/psg_audio_mixer.sv
// PSG three-channel stereo mixer with box-filter decimation to 16-bit samples.
// Optional DC-blocking high-pass per channel when PSG_MIXER_DCBLOCK_EN is defined.
module psg_audio_mixer #(
   parameter int unsigned AVG_LOG2 = 4
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        CE,
   input  logic [7:0]  CH_A,
   input  logic [7:0]  CH_B,
   input  logic [7:0]  CH_C,
   input  logic [1:0]  STEREO_MODE,
   output logic [15:0] OUT_L,
   output logic [15:0] OUT_R,
   output logic        OUT_VALID
);

   localparam int unsigned AccW = 10 + AVG_LOG2;

   logic [AVG_LOG2-1:0] tick_q, tick_d;
   logic [1:0]          mode_q, mode_d;
   logic [AccW-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [1:0]          mode_eff;
   logic [9:0]          a1, b1, c1, a2, b2, c2;
   logic [9:0]          mix_l, mix_r;
   logic [AccW-1:0]     total_l, total_r;
   logic [9:0]          avg_l, avg_r;
   logic                win_done;

   // The first tick of a window mixes with the mode it is latching.
   always_comb begin
      mode_eff = (tick_q == '0) ? STEREO_MODE : mode_q;
      a1 = {2'b00, CH_A};
      b1 = {2'b00, CH_B};
      c1 = {2'b00, CH_C};
      a2 = {1'b0, CH_A, 1'b0};
      b2 = {1'b0, CH_B, 1'b0};
      c2 = {1'b0, CH_C, 1'b0};
      case (mode_eff)
         2'd1: begin
            mix_l = a2 + b1;
            mix_r = c2 + b1;
         end
         2'd2: begin
            mix_l = a2 + c1;
            mix_r = b2 + c1;
         end
         default: begin
            mix_l = a1 + b1 + c1;
            mix_r = a1 + b1 + c1;
         end
      endcase
   end

   always_comb begin
      tick_d   = tick_q;
      mode_d   = mode_q;
      acc_l_d  = acc_l_q;
      acc_r_d  = acc_r_q;
      win_done = 1'b0;
      total_l  = acc_l_q + AccW'(mix_l);
      total_r  = acc_r_q + AccW'(mix_r);
      avg_l    = 10'(total_l >> AVG_LOG2);
      avg_r    = 10'(total_r >> AVG_LOG2);
      if (CE) begin
         tick_d = tick_q + AVG_LOG2'(1);
         if (tick_q == '0) mode_d = STEREO_MODE;
         if (&tick_q) begin
            acc_l_d  = '0;
            acc_r_d  = '0;
            win_done = 1'b1;
         end else begin
            acc_l_d = total_l;
            acc_r_d = total_r;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tick_q  <= '0;
         mode_q  <= 2'd0;
         acc_l_q <= '0;
         acc_r_q <= '0;
      end else begin
         tick_q  <= tick_d;
         mode_q  <= mode_d;
         acc_l_q <= acc_l_d;
         acc_r_q <= acc_r_d;
      end
   end

`ifdef PSG_MIXER_DCBLOCK_EN
   logic [9:0]  avg_l_q, avg_l_d, avg_r_q, avg_r_d;
   logic        avg_vld_q, avg_vld_d;
   logic [15:0] xp_l_q, xp_l_d, xp_r_q, xp_r_d;
   logic [15:0] y_l_q, y_l_d, y_r_q, y_r_d;
   logic        valid_q, valid_d;
   logic [15:0] x_l, x_r;

   // y = x - x' + y' - y'/256 in 18 bits, saturated to signed 16.
   function automatic logic [15:0] dc_block(input logic [15:0] x, input logic [15:0] xp,
                                            input logic [15:0] yp);
      logic signed [17:0] s;
      logic signed [17:0] ye;
      ye = $signed({{2{yp[15]}}, yp});
      s  = $signed({2'b00, x}) - $signed({2'b00, xp}) + ye - (ye >>> 8);
      if (s > 18'sd32767) return 16'h7fff;
      else if (s < -18'sd32768) return 16'h8000;
      else return s[15:0];
   endfunction

   always_comb begin
      avg_l_d   = win_done ? avg_l : avg_l_q;
      avg_r_d   = win_done ? avg_r : avg_r_q;
      avg_vld_d = win_done;
      x_l       = {1'b0, avg_l_q, 5'b0};
      x_r       = {1'b0, avg_r_q, 5'b0};
      xp_l_d    = xp_l_q;
      xp_r_d    = xp_r_q;
      y_l_d     = y_l_q;
      y_r_d     = y_r_q;
      valid_d   = avg_vld_q;
      if (avg_vld_q) begin
         xp_l_d = x_l;
         xp_r_d = x_r;
         y_l_d  = dc_block(x_l, xp_l_q, y_l_q);
         y_r_d  = dc_block(x_r, xp_r_q, y_r_q);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         avg_l_q   <= '0;
         avg_r_q   <= '0;
         avg_vld_q <= 1'b0;
         xp_l_q    <= '0;
         xp_r_q    <= '0;
         y_l_q     <= '0;
         y_r_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         avg_l_q   <= avg_l_d;
         avg_r_q   <= avg_r_d;
         avg_vld_q <= avg_vld_d;
         xp_l_q    <= xp_l_d;
         xp_r_q    <= xp_r_d;
         y_l_q     <= y_l_d;
         y_r_q     <= y_r_d;
         valid_q   <= valid_d;
      end
   end

   assign OUT_L     = y_l_q;
   assign OUT_R     = y_r_q;
   assign OUT_VALID = valid_q;
`else
   logic [15:0] out_l_q, out_l_d, out_r_q, out_r_d;
   logic        valid_q, valid_d;

   always_comb begin
      out_l_d = win_done ? {avg_l, 6'b0} : out_l_q;
      out_r_d = win_done ? {avg_r, 6'b0} : out_r_q;
      valid_d = win_done;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         out_l_q <= '0;
         out_r_q <= '0;
         valid_q <= 1'b0;
      end else begin
         out_l_q <= out_l_d;
         out_r_q <= out_r_d;
         valid_q <= valid_d;
      end
   end

   assign OUT_L     = out_l_q;
   assign OUT_R     = out_r_q;
   assign OUT_VALID = valid_q;
`endif

endmodule

// File: tb/tb_psg_audio_mixer.sv
// Directed bench for psg_audio_mixer in its default (unfiltered) build, AVG_LOG2 = 4.
module tb_psg_audio_mixer;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CE = 1'b0;
   logic [7:0]  CH_A = '0, CH_B = '0, CH_C = '0;
   logic [1:0]  STEREO_MODE = '0;
   logic [15:0] OUT_L, OUT_R;
   logic        OUT_VALID;

   int n_vec  = 0;
   int n_fail = 0;

   psg_audio_mixer #(.AVG_LOG2(4)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .CE          (CE),
      .CH_A        (CH_A),
      .CH_B        (CH_B),
      .CH_C        (CH_C),
      .STEREO_MODE (STEREO_MODE),
      .OUT_L       (OUT_L),
      .OUT_R       (OUT_R),
      .OUT_VALID   (OUT_VALID)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ce);
      CE = ce;
      @(posedge CLK);
      #1;
   endtask

   // n CE ticks, each followed by gap idle clocks; counts valid pulses, keeps last sample.
   task automatic run_ticks(input int n, input int gap, output int nv,
                            output logic [15:0] ll, output logic [15:0] rr);
      nv = 0;
      ll = '0;
      rr = '0;
      for (int i = 0; i < n; i++) begin
         step(1'b1);
         if (OUT_VALID) begin nv++; ll = OUT_L; rr = OUT_R; end
         for (int g = 0; g < gap; g++) begin
            step(1'b0);
            if (OUT_VALID) begin nv++; ll = OUT_L; rr = OUT_R; end
         end
      end
   endtask

   initial begin
      int          nv;
      logic [15:0] ll, rr;

      // Reset with random activity on inputs
      for (int i = 0; i < 5; i++) begin
         CH_A = 8'($urandom);
         CH_B = 8'($urandom);
         CH_C = 8'($urandom);
         STEREO_MODE = 2'($urandom);
         step(1'($urandom));
      end
      chk("rst_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("rst_l", {16'd0, OUT_L}, 32'd0);
      chk("rst_r", {16'd0, OUT_R}, 32'd0);

      // Release; full scale ABC, first sample exactly after 16th CE
      RESET_N = 1'b1;
      CH_A = 8'hff; CH_B = 8'hff; CH_C = 8'hff; STEREO_MODE = 2'd1;
      run_ticks(15, 0, nv, ll, rr);
      chk("first_no_early_valid", nv, 32'd0);
      step(1'b1);
      chk("first_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("fs_l", {16'd0, OUT_L}, 32'h0000bf40);
      chk("fs_r", {16'd0, OUT_R}, 32'h0000bf40);
      step(1'b0);
      chk("valid_one_cycle", {31'd0, OUT_VALID}, 32'd0);

      // Full scale with CE every 3rd clock
      run_ticks(32, 2, nv, ll, rr);
      chk("fs_gap_count", nv, 32'd2);
      chk("fs_gap_l", {16'd0, ll}, 32'h0000bf40);
      chk("fs_gap_r", {16'd0, rr}, 32'h0000bf40);

      // ACB: L = 2A + C = 64, R = 2B + C = 32
      CH_A = 8'h10; CH_B = 8'h00; CH_C = 8'h20; STEREO_MODE = 2'd2;
      run_ticks(16, 0, nv, ll, rr);
      chk("acb_count", nv, 32'd1);
      chk("acb_l", {16'd0, ll}, 32'h00001000);
      chk("acb_r", {16'd0, rr}, 32'h00000800);

      // Outputs hold and no valid while CE is low
      step(1'b0); step(1'b0); step(1'b0);
      chk("hold_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("hold_l", {16'd0, OUT_L}, 32'h00001000);

      // Mono, A alternating 00/FF: sum 2040, avg 127 -> 0x1FC0
      CH_B = 8'h00; CH_C = 8'h00; STEREO_MODE = 2'd0;
      nv = 0;
      for (int i = 0; i < 16; i++) begin
         CH_A = (i % 2 == 1) ? 8'hff : 8'h00;
         step(1'b1);
         if (OUT_VALID) begin nv++; ll = OUT_L; rr = OUT_R; end
      end
      chk("mono_trunc_count", nv, 32'd1);
      chk("mono_trunc_l", {16'd0, ll}, 32'h00001fc0);
      chk("mono_trunc_r", {16'd0, rr}, 32'h00001fc0);

      // Mode 3 is mono: 0x30 + 0x20 + 0x10 = 96 -> 0x1800
      CH_A = 8'h30; CH_B = 8'h20; CH_C = 8'h10; STEREO_MODE = 2'd3;
      run_ticks(16, 0, nv, ll, rr);
      chk("mono3_l", {16'd0, ll}, 32'h00001800);
      chk("mono3_r", {16'd0, rr}, 32'h00001800);

      // ABC small: L = 2 + 2 = 4, R = 6 + 2 = 8
      CH_A = 8'h01; CH_B = 8'h02; CH_C = 8'h03; STEREO_MODE = 2'd1;
      run_ticks(16, 0, nv, ll, rr);
      chk("abc_small_l", {16'd0, ll}, 32'h00000100);
      chk("abc_small_r", {16'd0, rr}, 32'h00000200);

      // Mode change ABC -> ACB at tick 7 affects next window only
      CH_A = 8'h10; CH_B = 8'h00; CH_C = 8'h20; STEREO_MODE = 2'd1;
      run_ticks(7, 0, nv, ll, rr);
      STEREO_MODE = 2'd2;
      run_ticks(9, 0, nv, ll, rr);
      chk("modechg_cur_count", nv, 32'd1);
      chk("modechg_cur_l", {16'd0, ll}, 32'h00000800);
      chk("modechg_cur_r", {16'd0, rr}, 32'h00001000);
      run_ticks(16, 0, nv, ll, rr);
      chk("modechg_next_l", {16'd0, ll}, 32'h00001000);
      chk("modechg_next_r", {16'd0, rr}, 32'h00000800);

      // Reset at tick 7 discards the window
      run_ticks(7, 0, nv, ll, rr);
      RESET_N = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("midrst_l", {16'd0, OUT_L}, 32'd0);
      chk("midrst_r", {16'd0, OUT_R}, 32'd0);
      step(1'b1); step(1'b1);
      RESET_N = 1'b1;
      CH_A = 8'hff; CH_B = 8'hff; CH_C = 8'hff; STEREO_MODE = 2'd1;
      run_ticks(15, 0, nv, ll, rr);
      chk("midrst_no_early", nv, 32'd0);
      step(1'b1);
      chk("midrst_valid_after", {31'd0, OUT_VALID}, 32'd1);
      chk("midrst_l_after", {16'd0, OUT_L}, 32'h0000bf40);
      chk("midrst_r_after", {16'd0, OUT_R}, 32'h0000bf40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
